fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the write port of one `fifo` instance among NUM_REQ producers.
- Uses a valid/ready handshake on each producer port.
- Drives a registered write strobe and data into the FIFO.
- Tracks FIFO free space with a credit counter, so the FIFO is never written while full, including the write held in the output register.
- Sits between dispatch-side producers and the shared `fifo`. All data is word32_t from data_types.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ENTRIES_POW2, 3, same value as the attached fifo. Usable capacity is CAPACITY = 2**ENTRIES_POW2 - 1 entries (7 at default).

Ports:
- clk_i  in  1  clock; everything samples on posedge.
- reset_i  in  1  asynchronous, active-high reset. Shared with the attached fifo.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ x word32_t  per-requester write data.
- req_ready_o  out  NUM_REQ  one-hot grant/ready; at most one bit set.
- fifo_pop_i  in  1  FIFO performed a real read this cycle (read_i && !empty_o at the fifo).
- fifo_write_o  out  1  registered write strobe to fifo write_i.
- fifo_write_data_o  out  word32_t  registered data to fifo write_data_i.
- credits_o  out  ENTRIES_POW2  free FIFO slots not yet claimed.
- overflow_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, released on a clock edge):
  - credits = CAPACITY, rr_ptr = 0.
  - fifo_write_o = 0, fifo_write_data_o = 0, overflow_err_o = 0.
  - req_ready_o = 0 while reset_i is high.
- Grant logic (combinational):
  - If credits_o == 0, no grant.
  - Otherwise grant the first k with req_valid_i[k] = 1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready_o = onehot(k), or 0 if no valid request.
- Handshake rules:
  - Transfer occurs when req_valid_i[k] && req_ready_o[k].
  - Requesters hold valid and data stable until the transfer.
  - A requester's valid must not depend on its ready; ready may depend on valid.
- On transfer from requester k at edge N:
  - fifo_write_o = 1 and fifo_write_data_o = req_data_i[k] during cycle N+1; the FIFO captures the data at edge N+1.
  - rr_ptr <= (k+1) mod NUM_REQ.
- No transfer: fifo_write_o <= 0, fifo_write_data_o holds its value, rr_ptr holds.
- Throughput: one transfer per cycle sustained while credits > 0.
- Credit update:
  - credits <= credits - transfer + fifo_pop_i.
  - Transfer and pop in the same cycle leaves credits unchanged.
  - The grant decision uses the registered credits, so a pop at credits == 0 enables a grant only in the next cycle.
- Protocol error: fifo_pop_i while credits == CAPACITY and no transfer this cycle sets overflow_err_o = 1 (sticky until reset). Credits saturate at CAPACITY.
- Invariant: credits + FIFO occupancy + fifo_write_o == CAPACITY at every edge. Therefore a FIFO write never coincides with full_o.
- Reset mid-operation: a pending registered write is dropped and fifo_write_o falls immediately (async). The FIFO is cleared by the same reset, so credits = CAPACITY remains consistent.
- NUM_REQ = 1 degenerates to a credit-gated register stage; rr_ptr stays 0.

Test Plan:
1. Contention order: reset, then req_valid_i = 4'b1111 for one request each, data 1..4 → grants 0,1,2,3 on consecutive cycles; fifo_write_o high 4 cycles with data 1,2,3,4; credits_o 7→3.
2. Fill: req 1 continuously valid, data 10,11,..., no pops → exactly 7 transfers (10..16), then req_ready_o = 0 and credits_o = 0; fifo full_o = 1 and no further write strobe.
3. Credit return: at credits_o = 0, pulse fifo_pop_i for one cycle → credits_o = 1 next cycle; the following edge grants data 17; credits_o returns to 0.
4. Simultaneous events: at credits_o = 3, a transfer and fifo_pop_i in the same cycle → credits_o stays 3; fifo_write_o = 1 next cycle.
5. Fairness: req 0 and req 2 continuously valid, ample credits → grant sequence 0,2,0,2,...; neither requester waits more than 1 cycle between grants.
6. Reset and error: assert reset_i between edges while fifo_write_o = 1 → fifo_write_o = 0 immediately, credits_o = 7 after reset. Then pulse fifo_pop_i with no transfer → overflow_err_o = 1 stays set and credits_o stays 7.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Credit counter tracks unclaimed FIFO slots, counting the write held in the output register.
module fifo_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ENTRIES_POW2 = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0][31:0]      req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_pop_i,
    output logic                          fifo_write_o,
    output logic [31:0]                   fifo_write_data_o,
    output logic [ENTRIES_POW2-1:0]       credits_o,
    output logic                          overflow_err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // 2**ENTRIES_POW2 - 1 is exactly the all-ones value of the credit register.
    localparam logic [ENTRIES_POW2-1:0] CAPACITY = '1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;
    logic             grant_found;
    logic             transfer;
    logic [31:0]      grant_data;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % 32'(NUM_REQ));
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        transfer    = grant_found && (credits_o != '0) && !reset_i;
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        grant_data = req_data_i[grant_idx];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits_o         <= CAPACITY;
            rr_ptr            <= '0;
            fifo_write_o      <= 1'b0;
            fifo_write_data_o <= '0;
            overflow_err_o    <= 1'b0;
        end else begin
            fifo_write_o <= transfer;
            if (transfer) begin
                fifo_write_data_o <= grant_data;
                rr_ptr            <= PTR_W'((32'(grant_idx) + 32'd1) % 32'(NUM_REQ));
            end
            case ({transfer, fifo_pop_i})
                2'b10: credits_o <= credits_o - 1'b1;
                2'b01: begin
                    if (credits_o == CAPACITY) begin
                        overflow_err_o <= 1'b1;
                    end else begin
                        credits_o <= credits_o + 1'b1;
                    end
                end
                default: credits_o <= credits_o;
            endcase
        end
    end

endmodule
